// File: rtl/team_select.sv
// team_select: keyboard-driven team picker that launches the battle FSM and tallies its results
module team_select #(
  parameter logic [7:0] KEY_W     = 8'h1A,
  parameter logic [7:0] KEY_A     = 8'h04,
  parameter logic [7:0] KEY_S     = 8'h16,
  parameter logic [7:0] KEY_D     = 8'h07,
  parameter logic [7:0] KEY_ENTER = 8'h28,
  parameter logic [7:0] KEY_BACK  = 8'h2A
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [7:0]      keycode,
  input  logic            end_battle,
  input  logic            result,
  output logic [2:0][2:0] team,
  output logic            is_battle,
  output logic [1:0]      screen,
  output logic [2:0]      cursor,
  output logic [1:0]      pick_count,
  output logic [7:0]      picked_mask,
  output logic [7:0]      wins,
  output logic [7:0]      losses
);
  typedef enum logic [2:0] {
    TITLE   = 3'd0,
    SELECT  = 3'd1,
    BATTLE  = 3'd2,
    RESULT  = 3'd3,
    CONFIRM = 3'd4
  } state_t;
  state_t          state_q, state_d;
  logic [7:0]      key_q;
  logic [2:0][2:0] team_q, team_d;
  logic [2:0]      cursor_q, cursor_d;
  logic [1:0]      pick_count_q, pick_count_d;
  logic [7:0]      picked_mask_q, picked_mask_d;
  logic [7:0]      wins_q, wins_d;
  logic [7:0]      losses_q, losses_d;
  logic            ev, undo;
  logic [1:0]      last;
  // Next-state logic: only one key event per cycle acts, judged against the current state
  always_comb begin
    state_d       = state_q;
    team_d        = team_q;
    cursor_d      = cursor_q;
    pick_count_d  = pick_count_q;
    picked_mask_d = picked_mask_q;
    wins_d        = wins_q;
    losses_d      = losses_q;
    undo          = 1'b0;
    ev            = (keycode != 8'h00) && (keycode != key_q);
    last          = pick_count_q - 2'd1;
    case (state_q)
      TITLE: if (ev && keycode == KEY_ENTER) begin
        state_d       = SELECT;
        team_d        = '0;
        cursor_d      = '0;
        pick_count_d  = '0;
        picked_mask_d = '0;
      end
      SELECT: if (ev) begin
        case (keycode)
          KEY_W: cursor_d = cursor_q[2] ? cursor_q - 3'd4 : cursor_q;
          KEY_S: cursor_d = cursor_q[2] ? cursor_q : cursor_q + 3'd4;
          KEY_A: cursor_d = (cursor_q[1:0] != 2'd0) ? cursor_q - 3'd1 : cursor_q;
          KEY_D: cursor_d = (cursor_q[1:0] != 2'd3) ? cursor_q + 3'd1 : cursor_q;
          KEY_ENTER: if (!picked_mask_q[cursor_q]) begin
            team_d[pick_count_q]    = cursor_q;
            picked_mask_d[cursor_q] = 1'b1;
            pick_count_d            = pick_count_q + 2'd1;
            state_d                 = (pick_count_q == 2'd2) ? CONFIRM : SELECT;
          end
          KEY_BACK: begin
            undo    = pick_count_q != 2'd0;
            state_d = undo ? SELECT : TITLE;
          end
          default: ;
        endcase
      end
      CONFIRM: if (ev) begin
        state_d = (keycode == KEY_ENTER) ? BATTLE : (keycode == KEY_BACK) ? SELECT : CONFIRM;
        undo    = keycode == KEY_BACK;
      end
      BATTLE: if (end_battle) begin
        state_d  = RESULT;
        wins_d   = (result && !(&wins_q)) ? wins_q + 8'd1 : wins_q;
        losses_d = (!result && !(&losses_q)) ? losses_q + 8'd1 : losses_q;
      end
      RESULT: if (ev) state_d = (keycode == KEY_ENTER) ? SELECT : (keycode == KEY_BACK) ? TITLE : RESULT;
      default: state_d = TITLE;
    endcase
    if (undo) begin
      picked_mask_d[team_q[last]] = 1'b0;
      team_d[last]                = 3'd0;
      pick_count_d                = last;
    end
  end
  // State and key registers; Reset returns everything, including a live battle, to Title
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= TITLE;
      key_q         <= '0;
      team_q        <= '0;
      cursor_q      <= '0;
      pick_count_q  <= '0;
      picked_mask_q <= '0;
      wins_q        <= '0;
      losses_q      <= '0;
    end else begin
      state_q       <= state_d;
      key_q         <= keycode;
      team_q        <= team_d;
      cursor_q      <= cursor_d;
      pick_count_q  <= pick_count_d;
      picked_mask_q <= picked_mask_d;
      wins_q        <= wins_d;
      losses_q      <= losses_d;
    end
  end
  assign team        = team_q;
  assign cursor      = cursor_q;
  assign pick_count  = pick_count_q;
  assign picked_mask = picked_mask_q;
  assign wins        = wins_q;
  assign losses      = losses_q;
  assign is_battle   = state_q == BATTLE;
  assign screen      = (state_q == CONFIRM) ? 2'd1 : state_q[1:0];
endmodule
